// File: rtl/tree_dispatch_sched.sv
// Tree traversal scheduler: walks a node memory breadth-first from root 0,
// hands internal nodes to free PEs round-robin and queues leaf records.
module tree_dispatch_sched #(
  parameter int NODE_W = 201,
  parameter int ADDR_W = 4,
  parameter int NUM_PE = 9,
  parameter int QDEPTH = 16,
  parameter int RDEPTH = 16,
  localparam int PE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [NODE_W-1:0] ld_data,
  input  logic              start,
  input  logic [NUM_PE-1:0] pe_busy,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [NODE_W-1:0] disp_data,
  output logic [ADDR_W-1:0] disp_idx,
  output logic [PE_W-1:0]   disp_pe,
  input  logic              res_rd,
  output logic [NODE_W-1:0] res_data,
  output logic              res_empty,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   leaf_cnt,
  output logic [ADDR_W:0]   node_cnt
);

  localparam int QA_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int RA_W = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
  localparam int NDEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, FETCH, DECIDE, DISPATCH, DONE} state_t;
  state_t state, state_nx;

  logic [NODE_W-1:0] nmem [NDEPTH];
  logic [ADDR_W-1:0] wq_mem [QDEPTH];
  logic [NODE_W-1:0] rmem [RDEPTH];

  logic [QA_W:0]     wq_wr, wq_rd, wq_cnt, wq_free;
  logic [QA_W-1:0]   wq_wi, wq_wi1, wq_ri;
  logic [RA_W:0]     res_wr, res_rp, res_cnt;
  logic [RA_W-1:0]   res_wi;
  logic              wq_empty, res_full, res_pop;
  logic [NODE_W-1:0] node_q;
  logic [ADDR_W-1:0] idx_q, c1, c2;
  logic              is_leaf;
  logic [1:0]        nz;
  logic [PE_W-1:0]   last_pe, lock_pe, arb_pe, cand;
  logic              arb_found, lock;
  int                arb_c;
  logic              init, pop, leaf_wr, xfer_ok, set_err;

  assign wq_cnt   = wq_wr - wq_rd;
  assign wq_free  = (QA_W+1)'(QDEPTH) - wq_cnt;
  assign wq_empty = (wq_cnt == '0);
  assign wq_wi    = wq_wr[QA_W-1:0];
  assign wq_wi1   = wq_wi + 1'b1;
  assign wq_ri    = wq_rd[QA_W-1:0];

  assign res_cnt   = res_wr - res_rp;
  assign res_full  = (res_cnt == (RA_W+1)'(RDEPTH));
  assign res_empty = (res_cnt == '0);
  assign res_pop   = res_rd && !res_empty;
  assign res_wi    = res_wr[RA_W-1:0];
  assign res_data  = rmem[res_rp[RA_W-1:0]];

  assign c1      = node_q[NODE_W-1 -: ADDR_W];
  assign c2      = node_q[NODE_W-1-ADDR_W -: ADDR_W];
  assign is_leaf = (c1 == '0) && (c2 == '0);
  assign nz      = {1'b0, c1 != '0} + {1'b0, c2 != '0};

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign disp_data = node_q;
  assign disp_idx  = idx_q;
  // Once offered, the grant is frozen until the record is taken.
  assign disp_pe   = lock ? lock_pe : arb_pe;

  always_comb begin
    arb_found = 1'b0;
    arb_pe    = '0;
    arb_c     = 0;
    cand      = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      arb_c = int'(last_pe) + 1 + i;
      if (arb_c >= NUM_PE) arb_c = arb_c - NUM_PE;
      cand = PE_W'(arb_c);
      if (!arb_found && !pe_busy[cand]) begin
        arb_found = 1'b1;
        arb_pe    = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    init       = 1'b0;
    pop        = 1'b0;
    leaf_wr    = 1'b0;
    xfer_ok    = 1'b0;
    set_err    = 1'b0;
    disp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          init     = 1'b1;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        if (wq_empty) begin
          state_nx = DONE;
        end else if (node_cnt == CNT_MAX) begin
          set_err  = 1'b1;
          state_nx = DONE;
        end else begin
          pop      = 1'b1;
          state_nx = DECIDE;
        end
      end
      DECIDE: begin
        if (is_leaf) begin
          if (!res_full || res_pop) leaf_wr = 1'b1;
          else                      set_err = 1'b1;
          state_nx = FETCH;
        end else begin
          state_nx = DISPATCH;
        end
      end
      DISPATCH: begin
        disp_valid = lock || arb_found;
        if (disp_valid && disp_ready) begin
          if (wq_free < (QA_W+1)'(nz)) begin
            set_err  = 1'b1;
            state_nx = DONE;
          end else begin
            xfer_ok  = 1'b1;
            state_nx = FETCH;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wq_wr    <= '0;
      wq_rd    <= '0;
      res_wr   <= '0;
      res_rp   <= '0;
      leaf_cnt <= '0;
      node_cnt <= '0;
      err      <= 1'b0;
      last_pe  <= PE_W'(NUM_PE - 1);
      lock     <= 1'b0;
    end else begin
      lock <= (state == DISPATCH) && disp_valid && !disp_ready;
      if (init) begin
        wq_rd    <= '0;
        wq_wr    <= (QA_W+1)'(1);
        leaf_cnt <= '0;
        node_cnt <= '0;
        err      <= 1'b0;
      end
      if (pop) wq_rd <= wq_rd + 1'b1;
      if (xfer_ok) begin
        wq_wr   <= wq_wr + (QA_W+1)'(nz);
        last_pe <= disp_pe;
      end
      if (state == DECIDE && node_cnt != CNT_MAX) node_cnt <= node_cnt + 1'b1;
      if (leaf_wr) begin
        res_wr <= res_wr + 1'b1;
        if (leaf_cnt != CNT_MAX) leaf_cnt <= leaf_cnt + 1'b1;
      end
      if (set_err) err <= 1'b1;
      if (res_pop) res_rp <= res_rp + 1'b1;
    end
  end

  // Storage and datapath registers carry no reset.
  always_ff @(posedge clk) begin
    if (ld_we && !busy) nmem[ld_addr] <= ld_data;
    if (pop) begin
      idx_q  <= wq_mem[wq_ri];
      node_q <= nmem[wq_mem[wq_ri]];
    end
    if (init) wq_mem[0] <= '0;
    if (xfer_ok) begin
      if (c1 != '0) begin
        wq_mem[wq_wi] <= c1;
        if (c2 != '0) wq_mem[wq_wi1] <= c2;
      end else if (c2 != '0) begin
        wq_mem[wq_wi] <= c2;
      end
    end
    if (leaf_wr) rmem[res_wi] <= node_q;
    if (state == DISPATCH && disp_valid && !disp_ready && !lock) lock_pe <= arb_pe;
  end

endmodule

// File: tb/tb_tree_dispatch_sched.sv
// Directed scoreboard bench for tree_dispatch_sched; a second instance with a
// two-entry result FIFO shares the stimulus for the overflow cases.
module tb_tree_dispatch_sched;

  localparam int NODE_W = 201;
  localparam int ADDR_W = 4;
  localparam int NUM_PE = 9;
  localparam int PE_W   = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ld_we = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [NODE_W-1:0] ld_data = '0;
  logic              start = 1'b0;
  logic [NUM_PE-1:0] pe_busy = '0;
  logic              disp_ready = 1'b0;
  logic              res_rd = 1'b0;
  logic              res_rd2 = 1'b0;

  logic              disp_valid, disp_valid2;
  logic [NODE_W-1:0] disp_data, disp_data2;
  logic [ADDR_W-1:0] disp_idx, disp_idx2;
  logic [PE_W-1:0]   disp_pe, disp_pe2;
  logic [NODE_W-1:0] res_data, res_data2;
  logic              res_empty, res_empty2;
  logic              busy, busy2, done, done2, err, err2;
  logic [ADDR_W:0]   leaf_cnt, leaf_cnt2, node_cnt, node_cnt2;

  tree_dispatch_sched dut (
    .clk(clk), .reset(reset), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .pe_busy(pe_busy), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_data(disp_data), .disp_idx(disp_idx), .disp_pe(disp_pe), .res_rd(res_rd),
    .res_data(res_data), .res_empty(res_empty), .busy(busy), .done(done), .err(err),
    .leaf_cnt(leaf_cnt), .node_cnt(node_cnt));

  tree_dispatch_sched #(.RDEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .pe_busy(pe_busy), .disp_valid(disp_valid2), .disp_ready(disp_ready),
    .disp_data(disp_data2), .disp_idx(disp_idx2), .disp_pe(disp_pe2), .res_rd(res_rd2),
    .res_data(res_data2), .res_empty(res_empty2), .busy(busy2), .done(done2), .err(err2),
    .leaf_cnt(leaf_cnt2), .node_cnt(node_cnt2));

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] idx;
    logic [PE_W-1:0]   pe;
    logic [NODE_W-1:0] data;
  } disp_t;

  disp_t             dq[$];
  logic [NODE_W-1:0] rq[$];
  logic [NODE_W-1:0] rq2[$];
  int                total = 0;
  int                bad = 0;
  int                done_n, done2_n;
  logic              err_at_done;
  logic [ADDR_W:0]   leaf_at_done, node_at_done;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NODE_W-1:0] mk(input int c1, input int c2, input int tag);
    logic [NODE_W-1:0] r;
    logic [ADDR_W-1:0] a1, a2;
    a1 = c1[ADDR_W-1:0];
    a2 = c2[ADDR_W-1:0];
    r = '0;
    r[NODE_W-1 -: ADDR_W] = a1;
    r[NODE_W-1-ADDR_W -: ADDR_W] = a2;
    r[31:0] = 32'hA5A5_0000 + 32'(tag);
    r[150 -: 16] = 16'h3C00 + 16'(tag);
    return r;
  endfunction

  task automatic exp_disp(input int idx, input int pe, input logic [NODE_W-1:0] d);
    disp_t e;
    e.idx  = idx[ADDR_W-1:0];
    e.pe   = pe[PE_W-1:0];
    e.data = d;
    dq.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0; ld_we = 1'b0; pe_busy = '0;
    disp_ready = 1'b0; res_rd = 1'b0; res_rd2 = 1'b0;
    dq.delete(); rq.delete(); rq2.delete();
    @(negedge clk);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    chk("rst_disp_valid", 256'(disp_valid), 256'(0));
    chk("rst_res_empty", 256'(res_empty), 256'(1));
    chk("rst_res_empty2", 256'(res_empty2), 256'(1));
    chk("rst_leaf_cnt", 256'(leaf_cnt), 256'(0));
    chk("rst_node_cnt", 256'(node_cnt), 256'(0));
    reset = 1'b1;
  endtask

  task automatic ld(input int a, input logic [NODE_W-1:0] d);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = a[ADDR_W-1:0]; ld_data = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 256'(busy), 256'(1));
  endtask

  task automatic load_small();
    ld(0, mk(1, 2, 0));
    ld(1, mk(0, 0, 1));
    ld(2, mk(0, 0, 2));
  endtask

  task automatic load_full();
    ld(0, mk(1, 2, 0));
    ld(1, mk(3, 4, 1));
    ld(2, mk(5, 6, 2));
    for (int n = 3; n < 7; n++) ld(n, mk(0, 0, n));
  endtask

  // Drives disp_ready, checks every transfer against dq and holds during stalls.
  task automatic run(input int stall, input bit flip, input int maxcyc);
    int held_n = 0;
    int cyc = 0;
    bit seen = 1'b0;
    logic [NODE_W-1:0] cap_data;
    logic [PE_W-1:0]   cap_pe;
    logic [ADDR_W-1:0] cap_idx;
    disp_t e;
    done_n = 0; done2_n = 0;
    disp_ready = 1'b0;
    while (!seen && cyc < maxcyc) begin
      @(negedge clk);
      cyc++;
      if (done2) done2_n++;
      if (held_n > 0) begin
        chk("hold_valid", 256'(disp_valid), 256'(1));
        chk("hold_pe", 256'(disp_pe), 256'(cap_pe));
        chk("hold_idx", 256'(disp_idx), 256'(cap_idx));
        chk("hold_data", 256'(disp_data), 256'(cap_data));
      end
      if (disp_valid) begin
        if (held_n == 0) begin
          cap_data = disp_data; cap_pe = disp_pe; cap_idx = disp_idx;
        end
        if (held_n >= stall) begin
          disp_ready = 1'b1;
          total++;
          assert (dq.size() > 0) else begin
            bad++;
            $error("FAIL disp_extra: observed idx=%0d pe=%0d expected no dispatch", disp_idx, disp_pe);
          end
          if (dq.size() > 0) begin
            e = dq.pop_front();
            chk("disp_idx", 256'(disp_idx), 256'(e.idx));
            chk("disp_pe", 256'(disp_pe), 256'(e.pe));
            chk("disp_data", 256'(disp_data), 256'(e.data));
          end
          held_n = 0;
        end else begin
          disp_ready = 1'b0;
          held_n++;
          if (flip && held_n == 2) pe_busy = 9'h1FD;
        end
      end else begin
        disp_ready = 1'b0;
      end
      if (done) begin
        done_n++;
        seen = 1'b1;
        err_at_done = err; leaf_at_done = leaf_cnt; node_at_done = node_cnt;
      end
    end
    chk("done_seen", 256'(seen), 256'(1));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (done) done_n++;
      if (done2) done2_n++;
      if (k == 0) chk("busy_after_done", 256'(busy), 256'(0));
    end
    chk("done_pulses", 256'(done_n), 256'(1));
    chk("done2_pulses", 256'(done2_n), 256'(1));
    chk("disp_missing", 256'(dq.size()), 256'(0));
  endtask

  task automatic drain();
    logic [NODE_W-1:0] x;
    while (rq.size() > 0) begin
      x = rq.pop_front();
      chk("res_nonempty", 256'(res_empty), 256'(0));
      chk("res_data", 256'(res_data), 256'(x));
      res_rd = 1'b1;
      @(negedge clk);
      res_rd = 1'b0;
    end
    chk("res_empty_end", 256'(res_empty), 256'(1));
  endtask

  task automatic drain2();
    logic [NODE_W-1:0] x;
    while (rq2.size() > 0) begin
      x = rq2.pop_front();
      chk("res2_nonempty", 256'(res_empty2), 256'(0));
      chk("res2_data", 256'(res_data2), 256'(x));
      res_rd2 = 1'b1;
      @(negedge clk);
      res_rd2 = 1'b0;
    end
    chk("res2_empty_end", 256'(res_empty2), 256'(1));
  endtask

  initial begin
    // Root with two leaf children.
    do_reset();
    load_small();
    exp_disp(0, 0, mk(1, 2, 0));
    rq.push_back(mk(0, 0, 1)); rq.push_back(mk(0, 0, 2));
    start_pulse();
    run(0, 1'b0, 100);
    chk("small_err", 256'(err_at_done), 256'(0));
    chk("small_leaf_cnt", 256'(leaf_at_done), 256'(2));
    chk("small_node_cnt", 256'(node_at_done), 256'(3));
    drain();

    // Stalled dispatch: only PE0 free, ready low 5 cycles, PE set changes mid-stall.
    do_reset();
    load_small();
    pe_busy = 9'h1FE;
    exp_disp(0, 0, mk(1, 2, 0));
    rq.push_back(mk(0, 0, 1)); rq.push_back(mk(0, 0, 2));
    start_pulse();
    run(5, 1'b1, 100);
    chk("stall_err", 256'(err_at_done), 256'(0));
    chk("stall_leaf_cnt", 256'(leaf_at_done), 256'(2));
    drain();

    // Seven-node tree; the two-entry instance overflows its result FIFO.
    do_reset();
    load_full();
    exp_disp(0, 0, mk(1, 2, 0));
    exp_disp(1, 1, mk(3, 4, 1));
    exp_disp(2, 2, mk(5, 6, 2));
    for (int n = 3; n < 7; n++) rq.push_back(mk(0, 0, n));
    rq2.push_back(mk(0, 0, 3)); rq2.push_back(mk(0, 0, 4));
    start_pulse();
    run(0, 1'b0, 200);
    chk("full_err", 256'(err_at_done), 256'(0));
    chk("full_leaf_cnt", 256'(leaf_at_done), 256'(4));
    chk("full_node_cnt", 256'(node_at_done), 256'(7));
    chk("ovf_err2", 256'(err2), 256'(1));
    chk("ovf_leaf_cnt2", 256'(leaf_cnt2), 256'(2));
    drain();

    // Full result FIFO with a read in the write cycle: the leaf is kept.
    ld(0, mk(0, 0, 9));
    rq.push_back(mk(0, 0, 9));
    rq2.delete();
    rq2.push_back(mk(0, 0, 4)); rq2.push_back(mk(0, 0, 9));
    start_pulse();
    @(negedge clk);
    chk("rdwr_full2", 256'(res_empty2), 256'(0));
    res_rd2 = 1'b1;
    @(negedge clk);
    res_rd2 = 1'b0;
    run(0, 1'b0, 50);
    chk("rdwr_err2", 256'(err2), 256'(0));
    chk("rdwr_leaf_cnt2", 256'(leaf_cnt2), 256'(1));
    drain();
    drain2();

    // Self-loop on node 1 trips the visit guard.
    do_reset();
    ld(0, mk(1, 0, 0));
    ld(1, mk(1, 0, 1));
    for (int k = 0; k < 16; k++)
      exp_disp((k == 0) ? 0 : 1, k % NUM_PE, (k == 0) ? mk(1, 0, 0) : mk(1, 0, 1));
    start_pulse();
    run(0, 1'b0, 300);
    chk("loop_err", 256'(err_at_done), 256'(1));
    chk("loop_node_cnt", 256'(node_at_done), 256'(16));
    chk("loop_leaf_cnt", 256'(leaf_at_done), 256'(0));

    // Reset while a dispatch is pending, then rerun from retained memory.
    do_reset();
    load_small();
    start_pulse();
    disp_ready = 1'b0;
    for (int k = 0; k < 10 && !disp_valid; k++) @(negedge clk);
    chk("pre_rst_valid", 256'(disp_valid), 256'(1));
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 256'(disp_valid), 256'(0));
    chk("mid_rst_busy", 256'(busy), 256'(0));
    chk("mid_rst_done", 256'(done), 256'(0));
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_no_done", 256'(done), 256'(0));
    end
    exp_disp(0, 0, mk(1, 2, 0));
    rq.push_back(mk(0, 0, 1)); rq.push_back(mk(0, 0, 2));
    start_pulse();
    run(0, 1'b0, 100);
    chk("rerun_err", 256'(err_at_done), 256'(0));
    chk("rerun_leaf_cnt", 256'(leaf_at_done), 256'(2));
    chk("rerun_node_cnt", 256'(node_at_done), 256'(3));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
